// File: rtl/pila_if.sv
// Strobe/data bundle between the control unit (master) and the pila stack (slave).
interface pila_if #(
  parameter int PCW = 10,
  parameter int AW  = 4
);
  logic           w_push;
  logic           w_pop;
  logic           s_jal;
  logic [PCW-1:0] pc_ret;
  logic [15:0]    din;
  logic [15:0]    dout;
  logic [PCW-1:0] dout_pc;
  logic [AW:0]    sp;
  logic           empty;
  logic           full;
  logic           overflow;
  logic           underflow;

  modport master (
    output w_push, w_pop, s_jal, pc_ret, din,
    input  dout, dout_pc, sp, empty, full, overflow, underflow
  );

  modport slave (
    input  w_push, w_pop, s_jal, pc_ret, din,
    output dout, dout_pc, sp, empty, full, overflow, underflow
  );
endinterface

// File: rtl/pila.sv
// LIFO return/data stack with combinational top-of-stack.
// STACK_GUARD_EN: defined = drop pushes when full; undefined = circular overwrite of oldest entry.
module pila #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int PCW   = 10
) (
  input logic   clk,
  input logic   reset,
  pila_if.slave bus
);

  localparam logic [AW:0]   SP_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   SP_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] IDX_ONE = AW'(1);

  logic [15:0]   mem [DEPTH];
  logic [AW:0]   sp_q, sp_d;
  logic [AW-1:0] base_q, base_d;
  logic          ovf_q, unf_q;
  logic          ovf_set, unf_set;
  logic          wr_en;
  logic [AW-1:0] wr_idx, top_idx;
  logic [15:0]   wv, dout_c;
  logic          empty_c, full_c;

  // base_q rotates the physical window once the circular mode starts overwriting;
  // it stays zero otherwise, so the physical write index equals sp[AW-1:0].
  always_comb begin
    empty_c = (sp_q == '0);
    full_c  = (sp_q == SP_FULL);
    wv      = bus.s_jal ? 16'(bus.pc_ret) : bus.din;
    top_idx = base_q + sp_q[AW-1:0] - IDX_ONE;
    dout_c  = empty_c ? 16'h0000 : mem[top_idx];
  end

  always_comb begin
    sp_d    = sp_q;
    base_d  = base_q;
    wr_en   = 1'b0;
    wr_idx  = base_q + sp_q[AW-1:0];
    ovf_set = 1'b0;
    unf_set = 1'b0;
    case ({bus.w_push, bus.w_pop})
      2'b10: begin
        if (!full_c) begin
          wr_en = 1'b1;
          sp_d  = sp_q + SP_ONE;
        end else begin
          ovf_set = 1'b1;
`ifndef STACK_GUARD_EN
          wr_en  = 1'b1;
          base_d = base_q + IDX_ONE;
`endif
        end
      end
      2'b01: begin
        if (!empty_c) sp_d = sp_q - SP_ONE;
        else          unf_set = 1'b1;
      end
      2'b11: begin
        wr_en = 1'b1;
        if (!empty_c) begin
          wr_idx = top_idx;
        end else begin
          sp_d    = sp_q + SP_ONE;
          unf_set = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q   <= '0;
      base_q <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      sp_q   <= sp_d;
      base_q <= base_d;
      ovf_q  <= ovf_q | ovf_set;
      unf_q  <= unf_q | unf_set;
    end
  end

  // Storage is deliberately left uncleared by reset.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) mem[wr_idx] <= wv;
  end

  assign bus.dout      = dout_c;
  assign bus.dout_pc   = dout_c[PCW-1:0];
  assign bus.sp        = sp_q;
  assign bus.empty     = empty_c;
  assign bus.full      = full_c;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;

endmodule

// File: tb/tb_pila.sv
// Directed self-checking bench for pila; expectations follow the STACK_GUARD_EN build setting.
module tb_pila;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  pila_if #(.PCW(10), .AW(4)) bus ();

  pila #(.DEPTH(16), .AW(4), .PCW(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.w_push = 1'b0;
    bus.w_pop  = 1'b0;
    bus.s_jal  = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic push_word(input logic [15:0] v);
    bus.w_push = 1'b1; bus.w_pop = 1'b0; bus.s_jal = 1'b0; bus.din = v;
    tick();
    idle();
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (bus.sp !== 5'd0) begin n_bad++; $display("FAIL reset_sp: got %0d want 0", bus.sp); end
    n_cmp++; if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin n_bad++; $display("FAIL reset_empty_full: got %b%b want 10", bus.empty, bus.full); end
    n_cmp++; if (bus.dout !== 16'h0000) begin n_bad++; $display("FAIL reset_dout: got %h want 0000", bus.dout); end
    n_cmp++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin n_bad++; $display("FAIL reset_flags: got %b%b want 00", bus.overflow, bus.underflow); end
  endtask

  task automatic test_push_din();
    push_word(16'hA5A5);
    n_cmp++; if (bus.sp !== 5'd1) begin n_bad++; $display("FAIL push_sp: got %0d want 1", bus.sp); end
    n_cmp++; if (bus.dout !== 16'hA5A5) begin n_bad++; $display("FAIL push_dout: got %h want a5a5", bus.dout); end
    n_cmp++; if (bus.empty !== 1'b0) begin n_bad++; $display("FAIL push_empty: got %b want 0", bus.empty); end
  endtask

  task automatic test_jal();
    do_reset();
    bus.w_push = 1'b1; bus.s_jal = 1'b1; bus.pc_ret = 10'h155; bus.din = 16'hFFFF;
    tick();
    idle();
    bus.w_pop = 1'b1;
    #1;
    n_cmp++; if (bus.dout_pc !== 10'h155) begin n_bad++; $display("FAIL jal_dout_pc: got %h want 155", bus.dout_pc); end
    n_cmp++; if (bus.dout !== 16'h0155) begin n_bad++; $display("FAIL jal_dout: got %h want 0155", bus.dout); end
    tick();
    idle();
    n_cmp++; if (bus.sp !== 5'd0 || bus.empty !== 1'b1) begin n_bad++; $display("FAIL jal_after_pop: got sp=%0d empty=%b want 0/1", bus.sp, bus.empty); end
  endtask

  task automatic test_lifo();
    do_reset();
    for (int i = 1; i <= 4; i++) push_word(16'(i));
    n_cmp++; if (bus.sp !== 5'd4) begin n_bad++; $display("FAIL lifo_sp: got %0d want 4", bus.sp); end
    for (int i = 4; i >= 1; i--) begin
      bus.w_pop = 1'b1;
      #1;
      n_cmp++; if (bus.dout !== 16'(i)) begin n_bad++; $display("FAIL lifo_pop: got %h want %h", bus.dout, 16'(i)); end
      tick();
      idle();
    end
    n_cmp++; if (bus.empty !== 1'b1 || bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin n_bad++; $display("FAIL lifo_end: got empty=%b ovf=%b unf=%b want 1/0/0", bus.empty, bus.overflow, bus.underflow); end
  endtask

  task automatic test_replace();
    do_reset();
    push_word(16'h0011);
    bus.w_push = 1'b1; bus.w_pop = 1'b1; bus.din = 16'h0022;
    tick();
    idle();
    n_cmp++; if (bus.sp !== 5'd1) begin n_bad++; $display("FAIL replace_sp: got %0d want 1", bus.sp); end
    n_cmp++; if (bus.dout !== 16'h0022) begin n_bad++; $display("FAIL replace_dout: got %h want 0022", bus.dout); end
    n_cmp++; if (bus.underflow !== 1'b0) begin n_bad++; $display("FAIL replace_unf: got %b want 0", bus.underflow); end
  endtask

  task automatic test_underflow();
    do_reset();
    bus.w_pop = 1'b1;
    tick();
    idle();
    n_cmp++; if (bus.underflow !== 1'b1 || bus.sp !== 5'd0) begin n_bad++; $display("FAIL unf_pop: got unf=%b sp=%0d want 1/0", bus.underflow, bus.sp); end
    n_cmp++; if (bus.dout !== 16'h0000) begin n_bad++; $display("FAIL unf_dout: got %h want 0000", bus.dout); end
    push_word(16'h0005);
    push_word(16'h0006);
    n_cmp++; if (bus.underflow !== 1'b1 || bus.sp !== 5'd2) begin n_bad++; $display("FAIL unf_sticky: got unf=%b sp=%0d want 1/2", bus.underflow, bus.sp); end
    do_reset();
    n_cmp++; if (bus.underflow !== 1'b0) begin n_bad++; $display("FAIL unf_clear: got %b want 0", bus.underflow); end
    bus.w_push = 1'b1; bus.w_pop = 1'b1; bus.din = 16'h0033;
    tick();
    idle();
    n_cmp++; if (bus.sp !== 5'd1 || bus.dout !== 16'h0033 || bus.underflow !== 1'b1) begin n_bad++; $display("FAIL both_empty: got sp=%0d dout=%h unf=%b want 1/0033/1", bus.sp, bus.dout, bus.underflow); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.w_push = 1'b1; bus.s_jal = 1'b1; bus.pc_ret = 10'h2AA;
    tick();
    idle();
    do_reset();
    bus.w_pop = 1'b1;
    tick();
    idle();
    n_cmp++; if (bus.sp !== 5'd0 || bus.underflow !== 1'b1) begin n_bad++; $display("FAIL reset_mid: got sp=%0d unf=%b want 0/1", bus.sp, bus.underflow); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 16; i++) push_word(16'(i));
    n_cmp++; if (bus.full !== 1'b1 || bus.sp !== 5'd16 || bus.overflow !== 1'b0) begin n_bad++; $display("FAIL full_fill: got full=%b sp=%0d ovf=%b want 1/16/0", bus.full, bus.sp, bus.overflow); end
    push_word(16'h00FF);
    n_cmp++; if (bus.overflow !== 1'b1 || bus.sp !== 5'd16) begin n_bad++; $display("FAIL full_ovf: got ovf=%b sp=%0d want 1/16", bus.overflow, bus.sp); end
`ifdef STACK_GUARD_EN
    n_cmp++; if (bus.dout !== 16'h000F) begin n_bad++; $display("FAIL full_dout: got %h want 000f", bus.dout); end
    for (int i = 15; i >= 0; i--) begin
      bus.w_pop = 1'b1;
      #1;
      n_cmp++; if (bus.dout !== 16'(i)) begin n_bad++; $display("FAIL full_pop: got %h want %h", bus.dout, 16'(i)); end
      tick();
      idle();
    end
`else
    n_cmp++; if (bus.dout !== 16'h00FF) begin n_bad++; $display("FAIL full_dout: got %h want 00ff", bus.dout); end
    for (int i = 16; i >= 1; i--) begin
      logic [15:0] exp_v;
      exp_v = (i == 16) ? 16'h00FF : 16'(i);
      bus.w_pop = 1'b1;
      #1;
      n_cmp++; if (bus.dout !== exp_v) begin n_bad++; $display("FAIL full_pop: got %h want %h", bus.dout, exp_v); end
      tick();
      idle();
    end
`endif
    n_cmp++; if (bus.empty !== 1'b1 || bus.overflow !== 1'b1 || bus.underflow !== 1'b0) begin n_bad++; $display("FAIL full_end: got empty=%b ovf=%b unf=%b want 1/1/0", bus.empty, bus.overflow, bus.underflow); end
  endtask

  initial begin
    bus.w_push = 1'b0;
    bus.w_pop  = 1'b0;
    bus.s_jal  = 1'b0;
    bus.pc_ret = '0;
    bus.din    = '0;
    test_reset();
    test_push_din();
    test_jal();
    test_lifo();
    test_replace();
    test_underflow();
    test_reset_mid();
    test_full();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
